// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: owns head/tail pointers, per-entry valid/done bits and the storage clear vector.
// Latency: alloc grant and completion gating are combinational; a completed head is offered to commit the next cycle.
// Backpressure: allocReady_o drops while full; the head is held until commitAck_i; flush overrides everything.
module rob_ctrl #(
    parameter int ROBsize  = 32,
    parameter int addrSize = $clog2(ROBsize)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                allocReq_i,
    output logic                allocReady_o,
    output logic [addrSize-1:0] allocTag_o,
    output logic                decodeWriteEn_o,
    output logic [addrSize-1:0] decodeWriteAddr_o,
    input  logic                complValid_i,
    input  logic [addrSize-1:0] complTag_i,
    output logic                completionWriteEn_o,
    output logic [addrSize-1:0] completionWriteAddr_o,
    output logic                commitValid_o,
    output logic [addrSize-1:0] commitTag_o,
    input  logic                commitAck_i,
    input  logic                flush_i,
    output logic [ROBsize-1:0]  resets_o,
    output logic [addrSize:0]   count_o,
    output logic                full_o,
    output logic                empty_o
);
    localparam logic [addrSize:0] ptrOne = (addrSize+1)'(1);

    // Pointers carry an extra wrap bit so full and empty stay distinguishable.
    logic [addrSize:0]   head;
    logic [addrSize:0]   tail;
    logic [ROBsize-1:0]  valid;
    logic [ROBsize-1:0]  done;
    logic [addrSize-1:0] headIdx;
    logic [addrSize-1:0] tailIdx;
    logic                allocFire;
    logic                complFire;
    logic                commitFire;

    assign headIdx = head[addrSize-1:0];
    assign tailIdx = tail[addrSize-1:0];

    assign full_o       = (headIdx == tailIdx) && (head[addrSize] != tail[addrSize]);
    assign empty_o      = (head == tail);
    assign count_o      = tail - head;
    assign allocReady_o = ~full_o;

    assign allocFire         = allocReq_i & allocReady_o & ~flush_i;
    assign allocTag_o        = tailIdx;
    assign decodeWriteEn_o   = allocFire;
    assign decodeWriteAddr_o = tailIdx;

    assign complFire             = complValid_i & valid[complTag_i] & ~flush_i;
    assign completionWriteEn_o   = complFire;
    assign completionWriteAddr_o = complTag_i;

    assign commitValid_o = valid[headIdx] & done[headIdx];
    assign commitFire    = commitValid_o & commitAck_i & ~flush_i;
    assign commitTag_o   = headIdx;

    always_comb begin
        resets_o = {ROBsize{~rst_n_i | flush_i}};
        if (commitFire) begin
            resets_o[headIdx] = 1'b1;
        end
    end

    // Alloc, completion and commit never touch the same entry in one cycle:
    // alloc needs a free tail slot, which is neither valid nor the valid head.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (allocFire) begin
                valid[tailIdx] <= 1'b1;
                done[tailIdx]  <= 1'b0;
                tail           <= tail + ptrOne;
            end
            if (complFire) begin
                done[complTag_i] <= 1'b1;
            end
            if (commitFire) begin
                valid[headIdx] <= 1'b0;
                done[headIdx]  <= 1'b0;
                head           <= head + ptrOne;
            end
        end
    end
endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: occupancy model (oldest tag + entry count + done set) checked every cycle, plus directed literals.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_rob_ctrl;
    localparam int N = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          allocReq = 1'b0;
    logic          allocReady;
    logic [AW-1:0] allocTag;
    logic          decodeWriteEn;
    logic [AW-1:0] decodeWriteAddr;
    logic          complValid = 1'b0;
    logic [AW-1:0] complTag = '0;
    logic          completionWriteEn;
    logic [AW-1:0] completionWriteAddr;
    logic          commitValid;
    logic [AW-1:0] commitTag;
    logic          commitAck = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  resets;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int nChecks = 0;
    int nFail = 0;

    rob_ctrl #(.ROBsize(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .allocReq_i(allocReq), .allocReady_o(allocReady), .allocTag_o(allocTag),
        .decodeWriteEn_o(decodeWriteEn), .decodeWriteAddr_o(decodeWriteAddr),
        .complValid_i(complValid), .complTag_i(complTag),
        .completionWriteEn_o(completionWriteEn), .completionWriteAddr_o(completionWriteAddr),
        .commitValid_o(commitValid), .commitTag_o(commitTag), .commitAck_i(commitAck),
        .flush_i(flush), .resets_o(resets), .count_o(count), .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mHead is the oldest tag, mCount the number in flight, mDone the completed tags.
    int      mHead = 0;
    int      mCount = 0;
    bit [N-1:0] mDone = '0;

    function automatic bit inFlight(input int t);
        return ((t - mHead + N) % N) < mCount;
    endfunction

    function automatic bit expCommitValid();
        return (mCount > 0) && mDone[mHead];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHead = 0; mCount = 0; mDone = '0;
        end else if (flush) begin
            mHead = 0; mCount = 0; mDone = '0;
        end else begin
            bit aF, cF, kF;
            int tailTag;
            tailTag = (mHead + mCount) % N;
            aF = allocReq && (mCount < N);
            cF = complValid && inFlight(int'(complTag));
            kF = expCommitValid() && commitAck;
            if (cF) mDone[complTag] = 1'b1;
            if (kF) begin
                mDone[mHead] = 1'b0;
                mHead = (mHead + 1) % N;
                mCount--;
            end
            if (aF) begin
                mDone[tailTag] = 1'b0;
                mCount++;
            end
        end
    end

    always @(negedge clk) begin
        bit eFull, eAllocEn, eComplEn, eCommitFire;
        logic [N-1:0] eResets;
        eFull = (mCount == N);
        eAllocEn = allocReq && !eFull && !flush && rst_n;
        eComplEn = complValid && inFlight(int'(complTag)) && !flush && rst_n;
        eCommitFire = expCommitValid() && commitAck && !flush && rst_n;
        eResets = (!rst_n || flush) ? {N{1'b1}} : (eCommitFire ? (N'(1) << mHead) : '0);
        chk("allocReady", 64'(allocReady), 64'(!eFull));
        chk("allocTag", 64'(allocTag), 64'((mHead + mCount) % N));
        chk("decodeWriteEn", 64'(decodeWriteEn), 64'(eAllocEn));
        chk("decodeWriteAddr", 64'(decodeWriteAddr), 64'((mHead + mCount) % N));
        chk("completionWriteEn", 64'(completionWriteEn), 64'(eComplEn));
        chk("completionWriteAddr", 64'(completionWriteAddr), 64'(complTag));
        chk("commitValid", 64'(commitValid), 64'(expCommitValid()));
        chk("commitTag", 64'(commitTag), 64'(mHead));
        chk("resets", 64'(resets), 64'(eResets));
        chk("count", 64'(count), 64'(mCount));
        chk("full", 64'(full), 64'(eFull));
        chk("empty", 64'(empty), 64'(mCount == 0));
    end

    task automatic step();
        @(posedge clk);
        #1;
        allocReq = 1'b0; complValid = 1'b0; commitAck = 1'b0; flush = 1'b0;
    endtask

    // Settle combinational outputs after driving, still well clear of either edge.
    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_resets", 64'(resets), 64'hFFFF_FFFF);
        chk("rst_allocReady", 64'(allocReady), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Fill: tags 0..31 back to back, then a refused 33rd request
        for (int i = 0; i < N; i++) begin
            allocReq = 1'b1; settle();
            chk("fill_tag", 64'(allocTag), 64'(i));
            chk("fill_en", 64'(decodeWriteEn), 64'd1);
            step();
        end
        allocReq = 1'b1; settle();
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(allocReady), 64'd0);
        chk("full_noalloc", 64'(decodeWriteEn), 64'd0);
        chk("full_count", 64'(count), 64'd32);
        step();

        // Full with head done: commit fires, alloc does not
        complValid = 1'b1; complTag = 5'd0; step();
        allocReq = 1'b1; commitAck = 1'b1; settle();
        chk("fc_commitValid", 64'(commitValid), 64'd1);
        chk("fc_noalloc", 64'(decodeWriteEn), 64'd0);
        chk("fc_resets", 64'(resets), 64'h1);
        step();
        chk("fc_count", 64'(count), 64'd31);
        allocReq = 1'b1; settle();
        chk("fc_alloc_next", 64'(decodeWriteEn), 64'd1);
        chk("fc_alloc_tag", 64'(allocTag), 64'd0);
        step();
        flush = 1'b1; step();

        // Out-of-order completion, in-order commit
        for (int i = 0; i < 3; i++) begin allocReq = 1'b1; step(); end
        complValid = 1'b1; complTag = 5'd2; step();
        chk("ooo_hold2", 64'(commitValid), 64'd0);
        complValid = 1'b1; complTag = 5'd1; step();
        chk("ooo_hold1", 64'(commitValid), 64'd0);
        complValid = 1'b1; complTag = 5'd0; settle();
        chk("ooo_not_yet", 64'(commitValid), 64'd0);
        step();
        chk("ooo_ready", 64'(commitValid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            commitAck = 1'b1; settle();
            chk("ooo_commitTag", 64'(commitTag), 64'(i));
            step();
        end
        chk("ooo_empty", 64'(empty), 64'd1);

        // Completion to an unallocated entry is dropped
        complValid = 1'b1; complTag = 5'd7; settle();
        chk("stray_compl", 64'(completionWriteEn), 64'd0);
        step();
        chk("stray_commit", 64'(commitValid), 64'd0);
        allocReq = 1'b1; complValid = 1'b1; complTag = 5'd3; settle();
        chk("stray_alloc_same_cycle", 64'(completionWriteEn), 64'd0);
        step();
        chk("stray_notdone", 64'(commitValid), 64'd0);
        commitAck = 1'b1; flush = 1'b1; step();

        // 40 alloc/commit pairs with two entries in flight: pointers wrap
        allocReq = 1'b1; step();
        allocReq = 1'b1; complValid = 1'b1; complTag = 5'd0; step();
        for (int k = 2; k < 42; k++) begin
            allocReq = 1'b1; commitAck = 1'b1;
            complValid = 1'b1; complTag = AW'((k - 1) % N); settle();
            chk("wrap_tag", 64'(allocTag), 64'(k % N));
            chk("wrap_commitTag", 64'(commitTag), 64'((k - 2) % N));
            chk("wrap_count", 64'(count), 64'd2);
            step();
        end
        chk("wrap_nofull", 64'(full), 64'd0);
        chk("wrap_noempty", 64'(empty), 64'd0);
        flush = 1'b1; step();

        // Flush with ten in flight and simultaneous alloc/complete/commit
        for (int i = 0; i < 10; i++) begin allocReq = 1'b1; step(); end
        complValid = 1'b1; complTag = 5'd0; step();
        flush = 1'b1; allocReq = 1'b1; commitAck = 1'b1; complValid = 1'b1; complTag = 5'd3; settle();
        chk("fl_resets", 64'(resets), 64'hFFFF_FFFF);
        chk("fl_noalloc", 64'(decodeWriteEn), 64'd0);
        chk("fl_nocompl", 64'(completionWriteEn), 64'd0);
        step();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_allocTag", 64'(allocTag), 64'd0);
        chk("fl_commitValid", 64'(commitValid), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
